// File: rtl/hft_pkg.sv
// Shared definitions for the ITCH message front end: message geometry,
// accepted opcodes and the enums used by the assembler and the parser.
package hft_pkg;

    localparam int NUM_WORDS = 9;

    localparam logic [7:0] OPC_ADD     = 8'h41;
    localparam logic [7:0] OPC_CANCEL  = 8'h58;
    localparam logic [7:0] OPC_EXECUTE = 8'h45;

    typedef enum logic [1:0] {
        ORDER_ADD     = 2'd0,
        ORDER_CANCEL  = 2'd1,
        ORDER_EXECUTE = 2'd2,
        ORDER_NONE    = 2'd3
    } order_t;

    typedef enum logic {
        TRADE_BUY  = 1'b0,
        TRADE_SELL = 1'b1
    } trade_t;

    typedef enum logic [1:0] {
        STOCK_0 = 2'd0,
        STOCK_1 = 2'd1,
        STOCK_2 = 2'd2,
        STOCK_3 = 2'd3
    } stock_t;

    // Map a message-type byte onto the order kind; ORDER_NONE means unsupported.
    function automatic order_t decode_opcode(input logic [7:0] opc);
        order_t kind;
        case (opc)
            OPC_ADD:     kind = ORDER_ADD;
            OPC_CANCEL:  kind = ORDER_CANCEL;
            OPC_EXECUTE: kind = ORDER_EXECUTE;
            default:     kind = ORDER_NONE;
        endcase
        return kind;
    endfunction

    function automatic logic opcode_valid(input logic [7:0] opc);
        return decode_opcode(opc) != ORDER_NONE;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; async active-low clear.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_clr_n,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);

    // Count events until the counter reaches all-ones, then hold.
    always_ff @(posedge i_clk or negedge i_clr_n) begin
        if (!i_clr_n) begin
            o_count <= '0;
        end else if (i_inc && (o_count != '1)) begin
            o_count <= o_count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/itch_msg_assembler.sv
// Collects fixed-length ITCH messages one word per cycle and presents the
// whole message in parallel to the parser. The final word bypasses the fill
// bank so a message can load while the previous one is being delivered.
module itch_msg_assembler
    import hft_pkg::*;
#(
    parameter int REG_WIDTH = 32,
    parameter int NUM_WORDS = hft_pkg::NUM_WORDS,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_word_valid,
    input  logic [REG_WIDTH-1:0] i_word,
    input  logic                 i_sof,
    output logic                 o_word_ready,
    input  logic                 i_book_is_busy,
    output logic [REG_WIDTH-1:0] o_reg_0,
    output logic [REG_WIDTH-1:0] o_reg_1,
    output logic [REG_WIDTH-1:0] o_reg_2,
    output logic [REG_WIDTH-1:0] o_reg_3,
    output logic [REG_WIDTH-1:0] o_reg_4,
    output logic [REG_WIDTH-1:0] o_reg_5,
    output logic [REG_WIDTH-1:0] o_reg_6,
    output logic [REG_WIDTH-1:0] o_reg_7,
    output logic [REG_WIDTH-1:0] o_reg_8,
    output logic                 o_msg_valid,
    output logic [CNT_WIDTH-1:0] o_msg_count,
    output logic [CNT_WIDTH-1:0] o_err_count,
    output logic                 o_drop
);

    localparam int                IDX_W    = $clog2(NUM_WORDS);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_WORDS - 1);

    logic [REG_WIDTH-1:0] fill_q [NUM_WORDS-1];
    logic [REG_WIDTH-1:0] reg_q  [NUM_WORDS];
    logic [IDX_W-1:0]     idx_q;
    logic                 msg_valid_q;
    logic                 drop_q;

    logic at_last;
    logic accept;
    logic resync;
    logic final_acc;
    logic opc_ok;
    logic load;
    logic deliver;

    // The only stall: last word waiting while the output holds an undeliverable message.
    assign at_last      = (idx_q == LAST_IDX);
    assign o_word_ready = !at_last || !msg_valid_q || !i_book_is_busy;
    assign accept       = i_word_valid && o_word_ready;
    // A start-of-frame mid-message abandons the partial message and restarts at word 0.
    assign resync       = accept && i_sof && (idx_q != '0);
    assign final_acc    = accept && at_last && !resync;
    assign opc_ok       = opcode_valid(fill_q[0][7:0]);
    assign load         = final_acc && opc_ok;
    assign deliver      = msg_valid_q && !i_book_is_busy;

    // Word index: advances per accepted word, wraps after the last, restarts on resync.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            idx_q <= '0;
        end else if (accept) begin
            if (resync) begin
                idx_q <= IDX_W'(1);
            end else if (at_last) begin
                idx_q <= '0;
            end else begin
                idx_q <= idx_q + IDX_W'(1);
            end
        end
    end

    // Fill bank holds words 0..N-2 of the message under construction.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NUM_WORDS - 1; i++) begin
                fill_q[i] <= '0;
            end
        end else if (accept) begin
            for (int i = 0; i < NUM_WORDS - 1; i++) begin
                if (resync) begin
                    if (i == 0) begin
                        fill_q[i] <= i_word;
                    end
                end else if (idx_q == IDX_W'(i)) begin
                    fill_q[i] <= i_word;
                end
            end
        end
    end

    // Output registers take the fill bank plus the final word only on a good message.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NUM_WORDS; i++) begin
                reg_q[i] <= '0;
            end
        end else if (load) begin
            for (int i = 0; i < NUM_WORDS - 1; i++) begin
                reg_q[i] <= fill_q[i];
            end
            reg_q[NUM_WORDS-1] <= i_word;
        end
    end

    // Message-valid: a load wins over a simultaneous delivery.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            msg_valid_q <= 1'b0;
        end else if (load) begin
            msg_valid_q <= 1'b1;
        end else if (deliver) begin
            msg_valid_q <= 1'b0;
        end
    end

    // Drop pulse for a discarded partial message or a complete message with a bad opcode.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            drop_q <= 1'b0;
        end else begin
            drop_q <= resync || (final_acc && !opc_ok);
        end
    end

    sat_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_msg_cnt (
        .i_clk   (i_clk),
        .i_clr_n (i_rst_n),
        .i_inc   (deliver),
        .o_count (o_msg_count)
    );

    sat_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_err_cnt (
        .i_clk   (i_clk),
        .i_clr_n (i_rst_n),
        .i_inc   (drop_q),
        .o_count (o_err_count)
    );

    assign o_msg_valid = msg_valid_q;
    assign o_drop      = drop_q;
    assign o_reg_0     = reg_q[0];
    assign o_reg_1     = reg_q[1];
    assign o_reg_2     = reg_q[2];
    assign o_reg_3     = reg_q[3];
    assign o_reg_4     = reg_q[4];
    assign o_reg_5     = reg_q[5];
    assign o_reg_6     = reg_q[6];
    assign o_reg_7     = reg_q[7];
    assign o_reg_8     = reg_q[8];

endmodule

// File: tb/tb_itch_msg_assembler.sv
// Bench for itch_msg_assembler: directed scenarios followed by random traffic,
// every cycle compared against a message-level reference model. Counters are
// built narrow so saturation is reached within a short run.
module tb_itch_msg_assembler;
    import hft_pkg::*;

    localparam int W     = 32;
    localparam int NW    = 9;
    localparam int CW    = 6;
    localparam int CMAX  = (1 << CW) - 1;

    logic          i_clk = 1'b0;
    logic          i_rst_n;
    logic          i_word_valid;
    logic [W-1:0]  i_word;
    logic          i_sof;
    logic          i_book_is_busy;
    logic          o_word_ready;
    logic [W-1:0]  o_reg_0, o_reg_1, o_reg_2, o_reg_3, o_reg_4;
    logic [W-1:0]  o_reg_5, o_reg_6, o_reg_7, o_reg_8;
    logic          o_msg_valid;
    logic [CW-1:0] o_msg_count;
    logic [CW-1:0] o_err_count;
    logic          o_drop;

    logic [W-1:0]  dut_regs [NW];

    itch_msg_assembler #(
        .REG_WIDTH (W),
        .NUM_WORDS (NW),
        .CNT_WIDTH (CW)
    ) dut (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_word_valid   (i_word_valid),
        .i_word         (i_word),
        .i_sof          (i_sof),
        .o_word_ready   (o_word_ready),
        .i_book_is_busy (i_book_is_busy),
        .o_reg_0        (o_reg_0),
        .o_reg_1        (o_reg_1),
        .o_reg_2        (o_reg_2),
        .o_reg_3        (o_reg_3),
        .o_reg_4        (o_reg_4),
        .o_reg_5        (o_reg_5),
        .o_reg_6        (o_reg_6),
        .o_reg_7        (o_reg_7),
        .o_reg_8        (o_reg_8),
        .o_msg_valid    (o_msg_valid),
        .o_msg_count    (o_msg_count),
        .o_err_count    (o_err_count),
        .o_drop         (o_drop)
    );

    assign dut_regs[0] = o_reg_0;
    assign dut_regs[1] = o_reg_1;
    assign dut_regs[2] = o_reg_2;
    assign dut_regs[3] = o_reg_3;
    assign dut_regs[4] = o_reg_4;
    assign dut_regs[5] = o_reg_5;
    assign dut_regs[6] = o_reg_6;
    assign dut_regs[7] = o_reg_7;
    assign dut_regs[8] = o_reg_8;

    always #5 i_clk = ~i_clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: partial message, message on offer, counts
    int          m_cur_n;
    logic [W-1:0] m_cur [NW];
    bit          m_held;
    logic [W-1:0] m_regs [NW];
    bit          m_drop;
    int          m_msg;
    int          m_err;
    bit          m_acc;

    int busy_left = 0;
    bit rand_busy = 0;
    bit saw_stall = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic int sat(input int x);
        return (x > CMAX) ? CMAX : x;
    endfunction

    function automatic bit opc_good(input logic [7:0] b);
        return b inside {8'h41, 8'h58, 8'h45};
    endfunction

    task automatic model_reset();
        m_cur_n = 0;
        m_held  = 0;
        m_drop  = 0;
        m_msg   = 0;
        m_err   = 0;
        m_acc   = 0;
        for (int k = 0; k < NW; k++) begin
            m_cur[k]  = '0;
            m_regs[k] = '0;
        end
    endtask

    task automatic get_busy(output bit b);
        if (busy_left > 0) begin
            b = 1;
            busy_left--;
        end else if (rand_busy) begin
            b = ($urandom_range(3, 0) == 0);
        end else begin
            b = 0;
        end
    endtask

    // One clock cycle: drive at the falling edge, check, then advance the model at the rising edge.
    task automatic step(input bit v, input logic [W-1:0] w, input bit sof, input bit busy);
        bit rdy;
        bit nd;
        i_word_valid   = v;
        i_word         = w;
        i_sof          = sof;
        i_book_is_busy = busy;
        #1;
        rdy = !((m_cur_n == NW - 1) && m_held && busy);
        chk("word_ready", o_word_ready, rdy);
        if (!o_word_ready) saw_stall = 1;
        chk("msg_valid", o_msg_valid, m_held);
        chk("drop", o_drop, m_drop);
        chk("msg_count", o_msg_count, m_msg);
        chk("err_count", o_err_count, m_err);
        for (int k = 0; k < NW; k++) begin
            chk($sformatf("reg%0d", k), dut_regs[k], m_regs[k]);
        end
        @(posedge i_clk);
        if (m_held && !busy) begin
            m_msg  = sat(m_msg + 1);
            m_held = 0;
        end
        m_err = sat(m_err + int'(m_drop));
        nd    = 0;
        m_acc = v && rdy;
        if (m_acc) begin
            if (sof && m_cur_n != 0) begin
                nd       = 1;
                m_cur[0] = w;
                m_cur_n  = 1;
            end else begin
                m_cur[m_cur_n] = w;
                m_cur_n++;
                if (m_cur_n == NW) begin
                    m_cur_n = 0;
                    if (opc_good(m_cur[0][7:0])) begin
                        m_regs = m_cur;
                        m_held = 1;
                    end else begin
                        nd = 1;
                    end
                end
            end
        end
        m_drop = nd;
        @(negedge i_clk);
    endtask

    task automatic idle(input int n);
        bit b;
        for (int k = 0; k < n; k++) begin
            get_busy(b);
            step(0, $urandom, 0, b);
        end
    endtask

    task automatic send_word(input logic [W-1:0] w, input bit sof);
        int tries;
        bit b;
        tries = 0;
        do begin
            get_busy(b);
            step(1, w, sof, b);
            tries++;
        end while (!m_acc && tries < 200);
        if (!m_acc) chk("accept_timeout", m_acc, 1);
    endtask

    task automatic send_msg(input logic [W-1:0] w0, input bit sof0, input int nw, input int gap_max);
        logic [W-1:0] w;
        int g;
        for (int k = 0; k < nw; k++) begin
            w = (k == 0) ? w0 : $urandom;
            g = (gap_max > 0 && $urandom_range(3, 0) == 0) ? $urandom_range(gap_max, 1) : 0;
            idle(g);
            send_word(w, (k == 0) ? sof0 : 1'b0);
        end
    endtask

    // Asynchronous reset in the middle of a cycle, outputs checked before any clock edge.
    task automatic do_reset();
        i_word_valid   = 0;
        i_sof          = 0;
        i_book_is_busy = 1;
        #2;
        i_rst_n = 0;
        #1;
        chk("rst_valid", o_msg_valid, 0);
        chk("rst_drop", o_drop, 0);
        chk("rst_msg_count", o_msg_count, 0);
        chk("rst_err_count", o_err_count, 0);
        chk("rst_ready", o_word_ready, 1);
        for (int k = 0; k < NW; k++) begin
            chk($sformatf("rst_reg%0d", k), dut_regs[k], 0);
        end
        model_reset();
        busy_left = 0;
        @(negedge i_clk);
        chk("rst_ready_hold", o_word_ready, 1);
        i_rst_n        = 1;
        i_book_is_busy = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] w0;
        int nt;
        bit force_sof;

        i_rst_n        = 0;
        i_word_valid   = 0;
        i_word         = '0;
        i_sof          = 0;
        i_book_is_busy = 0;
        model_reset();
        @(negedge i_clk);
        do_reset();

        // Single add message, no gaps, never busy
        send_msg(32'h0000_0141, 1, NW, 0);
        #1;
        chk("add_valid", o_msg_valid, 1);
        chk("add_reg0", o_reg_0, 32'h0000_0141);
        step(0, '0, 0, 0);
        chk("add_valid_fall", o_msg_valid, 0);
        chk("add_msg_count", o_msg_count, 1);
        idle(2);

        // Two back-to-back messages against a 20-cycle busy window
        do_reset();
        saw_stall = 0;
        busy_left = 20;
        w0 = $urandom; w0[7:0] = 8'h58;
        send_msg(w0, 1, NW, 0);
        w0 = $urandom; w0[7:0] = 8'h45;
        send_msg(w0, 1, NW, 0);
        idle(4);
        chk("bb_stall_seen", saw_stall, 1);
        chk("bb_msg_count", o_msg_count, 2);

        // Unsupported opcode is consumed and dropped
        do_reset();
        w0 = $urandom; w0[7:0] = 8'h5A;
        send_msg(w0, 1, NW, 0);
        idle(3);
        chk("badop_err_count", o_err_count, 1);
        chk("badop_msg_count", o_msg_count, 0);

        // Start-of-frame on word 5 restarts the message
        do_reset();
        w0 = $urandom; w0[7:0] = 8'h41;
        send_msg(w0, 1, 5, 0);
        w0 = $urandom; w0[7:0] = 8'h45;
        send_msg(w0, 1, NW, 0);
        idle(3);
        chk("resync_err_count", o_err_count, 1);
        chk("resync_msg_count", o_msg_count, 1);

        // Reset mid-message, then reset while a message is on offer
        do_reset();
        w0 = $urandom; w0[7:0] = 8'h41;
        send_msg(w0, 1, 4, 0);
        do_reset();
        busy_left = 30;
        send_msg(w0, 0, NW, 0);
        idle(1);
        chk("held_before_reset", o_msg_valid, 1);
        do_reset();
        idle(2);

        // Random traffic: gaps, busy, bad opcodes, truncated messages; counters saturate
        do_reset();
        rand_busy = 1;
        force_sof = 0;
        for (int m = 0; m < 200; m++) begin
            w0 = $urandom;
            if ($urandom_range(9, 0) < 8) begin
                case ($urandom_range(2, 0))
                    0:       w0[7:0] = 8'h41;
                    1:       w0[7:0] = 8'h58;
                    default: w0[7:0] = 8'h45;
                endcase
            end else begin
                while (opc_good(w0[7:0])) w0 = $urandom;
            end
            nt = ($urandom_range(9, 0) == 0) ? $urandom_range(NW - 1, 1) : NW;
            send_msg(w0, force_sof ? 1'b1 : 1'($urandom_range(1, 0)), nt, 2);
            force_sof = (nt != NW);
        end
        rand_busy = 0;
        idle(20);
        chk("sat_msg_count", o_msg_count, CMAX);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/itch_msg_assembler.md
ITCH_MSG_ASSEMBLER -- requirements
Module: itch_msg_assembler

Interface
REQ-001 Parameter REG_WIDTH, default 32, width of each message word and output register.
REQ-002 Parameter NUM_WORDS, default 9, words per message (reg0..reg8).
REQ-003 Parameter CNT_WIDTH, default 16, width of the statistics counters.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset: i_clk in 1, rising-edge clock; i_rst_n in 1, async active-low reset.
REQ-005 i_word_valid  in  1  upstream word present.
REQ-006 i_word  in  REG_WIDTH  message word, reg0 first, byte layout already packed.
REQ-007 i_sof  in  1  qualifies i_word as word 0 of a new message.
REQ-008 o_word_ready  out  1  block accepts i_word this cycle.
REQ-009 i_book_is_busy  in  1  downstream parser/book cannot take a message.
REQ-010 o_reg_0 .. o_reg_8  out  REG_WIDTH each  assembled message, feeds the parser i_reg_0..i_reg_8.
REQ-011 o_msg_valid  out  1  o_reg_* holds an undelivered message.
REQ-012 o_msg_count  out  CNT_WIDTH  messages delivered, saturating.
REQ-013 o_err_count  out  CNT_WIDTH  messages dropped, saturating.
REQ-014 o_drop  out  1  one-cycle pulse per dropped message.

Function
REQ-015 Word accept SHALL occur when i_word_valid && o_word_ready at a rising edge.
REQ-016 Word index counter idx (0..NUM_WORDS-1) SHALL increment per accept and wrap to 0 after word NUM_WORDS-1.
REQ-017 Words 0..NUM_WORDS-2 SHALL be stored in an internal fill bank; the final word SHALL be written directly, with the fill bank, into o_reg_* in the same edge.
REQ-018 Delivery SHALL occur at an edge with o_msg_valid && !i_book_is_busy; o_msg_valid SHALL clear at that edge unless a new message loads in the same edge.
REQ-019 o_word_ready SHALL be 1 when idx != NUM_WORDS-1, or !o_msg_valid, or !i_book_is_busy (combinational, 1 word/cycle sustained).
REQ-020 o_msg_valid SHALL rise in the cycle after the final word is accepted; latency last-word-accept to o_msg_valid = 1 cycle.
REQ-021 Simultaneous delivery and final-word load: o_reg_* SHALL take the new message and o_msg_valid SHALL stay 1.
REQ-022 o_reg_* SHALL stay stable while o_msg_valid is 1 and hold their last values after delivery.
REQ-023 Opcode check on word 0 bits [7:0]: 0x41 (add), 0x58 (cancel), 0x45 (execute) valid; any other value SHALL cause the whole message to be consumed and not loaded, o_drop pulsing in the cycle after the final word.
REQ-024 i_sof accepted with idx != 0: the partial message SHALL be discarded, o_drop SHALL pulse, and the word SHALL be stored as word 0 (idx becomes 1).
REQ-025 i_sof low on an accepted word with idx == 0: the word SHALL be taken as word 0 (no resync error).
REQ-026 o_msg_count SHALL increment per delivery; o_err_count SHALL increment per o_drop pulse; both SHALL saturate at all-ones.
REQ-027 o_drop and a delivery in the same cycle SHALL both be counted.

Reset
REQ-028 On i_rst_n low, o_reg_*, fill bank, idx, o_msg_valid, o_drop, o_msg_count and o_err_count SHALL clear to 0 asynchronously; o_word_ready SHALL read 1 during and after reset.
REQ-029 Reset mid-message or with o_msg_valid set SHALL discard the data without counting it.

Structure
REQ-030 Opcode constants (0x41, 0x58, 0x45), NUM_WORDS and the order_t/trade_t/stock_t enums SHALL live in shared package hft_pkg, used by both this block and the parser.
REQ-031 One sub-module SHALL be used: sat_counter (parameter width, inc, async active-low clear), instantiated twice.

Verification
REQ-032 Reset, then 9 words of an add message (word0 = 0x00_0001_41) with no gaps and busy = 0 -> o_msg_valid high for exactly 1 cycle, o_reg_0 = 0x00000141, o_msg_count = 1.
REQ-033 Two back-to-back messages with busy = 1 for 20 cycles -> o_word_ready = 0 on the second message's word 8; the first message is held stable; after busy falls, two deliveries occur in order, msg_count = 2.
REQ-034 Message with word0[7:0] = 0x5A -> o_drop pulses once, o_msg_valid stays 0, err_count = 1.
REQ-035 i_sof asserted on word 5 of a message -> o_drop pulses, the next 9 words deliver correctly, err_count = 1, msg_count = 1.
REQ-036 Reset asserted while idx = 4 and again while o_msg_valid = 1 -> all outputs 0 and no count change.
REQ-037 Preload o_msg_count to 0xFFFE via 2 deliveries after forced state -> it stops at 0xFFFF and does not wrap.
